// File: rtl/spi_slave_tx.sv
// SPI slave transmit: word via tx_valid/tx_ready, shifted LSB-first on MISO during the next ss_n-low frame; pin-to-action 2-3 clk.
// tx_ready low while a word is pending or a frame is active; SPI_SLAVE_TX_HOLD_EN adds a one-deep hold register that frees tx_ready.
module spi_slave_tx #(
    parameter int                    DATA_WIDTH    = 8,
    parameter bit                    CPOL          = 1'b0,
    parameter bit                    CPHA          = 1'b0,
    parameter logic [DATA_WIDTH-1:0] UNDERRUN_WORD = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  done,
    output logic                  underrun,
    output logic                  abort
);
    localparam int CW          = $clog2(DATA_WIDTH) + 1;
    localparam bit SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_HI} state_t;

    state_t                r_state;
    logic [2:0]            r_sclk_sync;
    logic [2:0]            r_ss_sync;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CW-1:0]         r_bitcnt;
    logic                  r_miso;
    logic                  r_oe;
    logic                  r_done;
    logic                  r_underrun;
    logic                  r_abort;

    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_ss_n;
    logic                  w_ss_fall;
    logic                  w_ss_rise;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_have;
    logic [DATA_WIDTH-1:0] w_frame_word;
    logic [DATA_WIDTH-1:0] w_entry_word;

    // Bit 0 is the first synchroniser stage, bit 2 the edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= {3{CPOL}};
            r_ss_sync   <= 3'b111;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_ss_sync   <= {r_ss_sync[1:0], ss_n};
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_sample    = SAMPLE_RISE ? w_sclk_rise : w_sclk_fall;
    assign w_shift     = SAMPLE_RISE ? w_sclk_fall : w_sclk_rise;
    assign w_ss_n      = r_ss_sync[1];
    assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
    assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
    assign w_start     = (r_state == IDLE) && w_ss_fall;
    assign w_accept    = tx_valid && tx_ready;

`ifdef SPI_SLAVE_TX_HOLD_EN
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;

    assign tx_ready     = !r_hold_full;
    assign w_have       = r_hold_full;
    assign w_frame_word = r_hold;

    // A word accepted on the frame-start clock stays held for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_start && r_hold_full)
                r_hold_full <= 1'b0;
            if (w_accept) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end
`else
    logic r_loaded;

    assign tx_ready     = (r_state == IDLE) && !r_loaded && w_ss_n;
    assign w_have       = r_loaded;
    assign w_frame_word = r_shreg;
`endif

    assign w_entry_word = w_have ? w_frame_word : UNDERRUN_WORD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bitcnt   <= '0;
            r_miso     <= 1'b0;
            r_oe       <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_abort    <= 1'b0;
`ifndef SPI_SLAVE_TX_HOLD_EN
            r_loaded   <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_abort    <= 1'b0;
`ifndef SPI_SLAVE_TX_HOLD_EN
            if (w_accept) begin
                r_shreg  <= tx_data;
                r_loaded <= 1'b1;
            end
`endif
            case (r_state)
                IDLE: begin
                    r_oe   <= 1'b0;
                    r_miso <= 1'b0;
                    if (w_start) begin
                        r_shreg    <= w_entry_word;
                        r_miso     <= w_entry_word[0];
                        r_oe       <= 1'b1;
                        r_bitcnt   <= '0;
                        r_underrun <= !w_have;
`ifndef SPI_SLAVE_TX_HOLD_EN
                        r_loaded   <= 1'b0;
`endif
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_ss_rise) begin
                        r_abort <= 1'b1;
                        r_oe    <= 1'b0;
                        r_miso  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_sample) begin
                        r_bitcnt <= r_bitcnt + CW'(1);
                        if (r_bitcnt == CW'(DATA_WIDTH - 1))
                            r_state <= DONE;
                    end else if (w_shift && (r_bitcnt != '0)) begin
                        // No shift before the first sample: CPHA=1 leading edge is a no-op.
                        r_shreg <= {1'b0, r_shreg[DATA_WIDTH-1:1]};
                        r_miso  <= r_shreg[1];
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (w_ss_n) begin
                        r_oe    <= 1'b0;
                        r_miso  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign miso     = r_miso;
    assign miso_oe  = r_oe;
    assign done     = r_done;
    assign underrun = r_underrun;
    assign abort    = r_abort;
endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: one mode-0 and one mode-3 instance driven by a bit-level SPI master model.
module tb_spi_slave_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sclk, ss_n, tx_valid, tx_ready, miso, miso_oe, done, underrun, abort;
    logic [7:0] tx_data [2];

    always #5 clk = ~clk;

    spi_slave_tx #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .UNDERRUN_WORD(8'hFF)) u_m0 (
        .clk(clk), .rst(rst), .sclk(sclk[0]), .ss_n(ss_n[0]), .tx_data(tx_data[0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .miso(miso[0]), .miso_oe(miso_oe[0]),
        .done(done[0]), .underrun(underrun[0]), .abort(abort[0]));

    spi_slave_tx #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .UNDERRUN_WORD(8'hFF)) u_m3 (
        .clk(clk), .rst(rst), .sclk(sclk[1]), .ss_n(ss_n[1]), .tx_data(tx_data[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .miso(miso[1]), .miso_oe(miso_oe[1]),
        .done(done[1]), .underrun(underrun[1]), .abort(abort[1]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt [2] = '{0, 0};
    int und_cnt  [2] = '{0, 0};
    int abt_cnt  [2] = '{0, 0};
    int done_at  [2] = '{0, 0};
    int und_at   [2] = '{0, 0};

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (done[m])     begin done_cnt[m]++; done_at[m] = cyc; end
            if (underrun[m]) begin und_cnt[m]++;  und_at[m]  = cyc; end
            if (abort[m])    abt_cnt[m]++;
        end
    end

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] sb_q [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic load_word(input int m, input logic [7:0] d);
        bit ok = 1'b0;
        tx_data[m] = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (tx_ready[m]) begin
                tx_valid[m] = 1'b1;
                @(negedge clk);
                tx_valid[m] = 1'b0;
                ok = 1'b1;
            end
        end
        if (!ok) chk("load_timeout", 0, 1);
    endtask

    // Master: mode 0 samples on the leading (rising) edge, mode 3 on the trailing (rising) edge.
    task automatic run_frame(input int m, input int nsample, output logic [7:0] cap,
                             output int samp_cyc, output int fall_cyc, output logic oe_seen);
        cap      = 8'h00;
        samp_cyc = 0;
        ss_n[m]  = 1'b0;
        fall_cyc = cyc;
        repeat (6) @(negedge clk);
        oe_seen = miso_oe[m];
        for (int i = 0; i < nsample; i++) begin
            if (m == 0) begin
                cap[i] = miso[m]; sclk[m] = 1'b1; samp_cyc = cyc;
                repeat (5) @(negedge clk);
                sclk[m] = 1'b0;
                repeat (5) @(negedge clk);
            end else begin
                sclk[m] = 1'b0;
                repeat (5) @(negedge clk);
                cap[i] = miso[m]; sclk[m] = 1'b1; samp_cyc = cyc;
                repeat (5) @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);
        ss_n[m] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        int         mode;
        bit         load;
        logic [7:0] data;
        int         nsample;
        bit         exp_done;
        bit         exp_und;
        bit         exp_abt;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] cap, exp_b, mask;
    int         samp_cyc, fall_cyc, d0, u0, a0, m;
    logic       oe_seen;

    initial begin
        vecs[0] = '{0, 1'b1, 8'h35, 8, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1, 1'b1, 8'hA6, 8, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{0, 1'b0, 8'h00, 8, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{0, 1'b1, 8'h0F, 3, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{0, 1'b0, 8'h00, 8, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1, 1'b0, 8'h00, 8, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{0, 1'b1, 8'hC3, 8, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; sclk = 2'b10; ss_n = 2'b11; tx_valid = 2'b00;
        tx_data[0] = 8'h00; tx_data[1] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(tx_ready), 3);
        chk("rst_miso", int'(miso), 0);
        chk("rst_oe", int'(miso_oe), 0);
        chk("rst_pulses", done_cnt[0] + und_cnt[0] + abt_cnt[0] + done_cnt[1] + und_cnt[1] + abt_cnt[1], 0);

        for (int v = 0; v < 7; v++) begin
            m  = vecs[v].mode;
            d0 = done_cnt[m]; u0 = und_cnt[m]; a0 = abt_cnt[m];
            if (vecs[v].load) load_word(m, vecs[v].data);
            exp_b = vecs[v].load ? vecs[v].data : 8'hFF;
            mask  = (vecs[v].nsample >= 8) ? 8'hFF : 8'((1 << vecs[v].nsample) - 1);
            sb_q.push_back(exp_b & mask);
            run_frame(m, vecs[v].nsample, cap, samp_cyc, fall_cyc, oe_seen);
            chk($sformatf("v%0d_bits", v), int'(cap), int'(sb_q.pop_front()));
            chk($sformatf("v%0d_done", v), done_cnt[m] - d0, int'(vecs[v].exp_done));
            chk($sformatf("v%0d_underrun", v), und_cnt[m] - u0, int'(vecs[v].exp_und));
            chk($sformatf("v%0d_abort", v), abt_cnt[m] - a0, int'(vecs[v].exp_abt));
            chk($sformatf("v%0d_oe", v), int'(oe_seen), 1);
            chk($sformatf("v%0d_ready_after", v), int'(tx_ready[m]), 1);
            if (vecs[v].exp_done && m == 0)
                chk_rng($sformatf("v%0d_done_lat", v), done_at[m] - samp_cyc, 3, 4);
            if (vecs[v].exp_und)
                chk_rng($sformatf("v%0d_und_lat", v), und_at[m] - fall_cyc, 2, 3);
        end

        // Reset mid-frame after 4 bits: outputs drop at once, no pulses, next word still correct.
        load_word(0, 8'h3C);
        d0 = done_cnt[0]; u0 = und_cnt[0]; a0 = abt_cnt[0];
        ss_n[0] = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sclk[0] = 1'b1; repeat (5) @(negedge clk);
            sclk[0] = 1'b0; repeat (5) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_oe", int'(miso_oe[0]), 0);
        chk("rst_mid_miso", int'(miso[0]), 0);
        ss_n[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_pulses", (done_cnt[0] - d0) + (abt_cnt[0] - a0) + (und_cnt[0] - u0), 0);
        d0 = done_cnt[0];
        load_word(0, 8'h5A);
        sb_q.push_back(8'h5A);
        run_frame(0, 8, cap, samp_cyc, fall_cyc, oe_seen);
        chk("post_rst_bits", int'(cap), int'(sb_q.pop_front()));
        chk("post_rst_done", done_cnt[0] - d0, 1);

`ifndef SPI_SLAVE_TX_HOLD_EN
        // A word offered once the frame has started is refused; the frame underruns.
        u0 = und_cnt[0];
        sb_q.push_back(8'hFF);
        fork
            run_frame(0, 8, cap, samp_cyc, fall_cyc, oe_seen);
            begin
                repeat (3) @(negedge clk);
                chk("busy_ready", int'(tx_ready[0]), 0);
                tx_data[0] = 8'h00; tx_valid[0] = 1'b1;
                repeat (20) @(negedge clk);
                tx_valid[0] = 1'b0;
            end
        join
        chk("busy_bits", int'(cap), int'(sb_q.pop_front()));
        chk("busy_underrun", und_cnt[0] - u0, 1);
`else
        // Second word loaded while frame 1 is shifting goes out in frame 2.
        u0 = und_cnt[0];
        load_word(0, 8'h11);
        sb_q.push_back(8'h11);
        sb_q.push_back(8'h22);
        fork
            run_frame(0, 8, cap, samp_cyc, fall_cyc, oe_seen);
            begin
                repeat (30) @(negedge clk);
                load_word(0, 8'h22);
            end
        join
        chk("hold_f1_bits", int'(cap), int'(sb_q.pop_front()));
        run_frame(0, 8, cap, samp_cyc, fall_cyc, oe_seen);
        chk("hold_f2_bits", int'(cap), int'(sb_q.pop_front()));
        chk("hold_underrun", und_cnt[0] - u0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
